// File: rtl/decode_issue_unit.sv
// Instruction queue feeding a registered RV32IM decoder, with an issue interlock
// that holds the next instruction back while a multi-cycle operation is in flight.
module decode_issue_unit #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int EN_M  = 1
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [PC_W-1:0]            out_pc,
  output logic [1:0]                 out_pcs,
  output logic                       out_regwrite,
  output logic                       out_memwrite,
  output logic                       out_memtoreg,
  output logic [1:0]                 out_alusrca,
  output logic [1:0]                 out_alusrcb,
  output logic [2:0]                 out_immsrc,
  output logic [3:0]                 out_aluctrl,
  output logic                       out_compsel,
  output logic                       out_mcycle_start,
  output logic [1:0]                 out_mcycle_op,
  output logic                       out_mcycle_sel,
  output logic [2:0]                 out_size_sel,
  output logic                       out_illegal,
  input  logic                       flush,
  input  logic                       mcycle_busy,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {RUN, MC_ARM, MC_WAIT} state_t;

  typedef struct packed {
    logic [1:0] pcs;
    logic       regwrite;
    logic       memwrite;
    logic       memtoreg;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [2:0] immsrc;
    logic [3:0] aluctrl;
    logic       compsel;
    logic       mcycle_start;
    logic [1:0] mcycle_op;
    logic       mcycle_sel;
    logic [2:0] size_sel;
    logic       illegal;
  } dec_t;

  localparam dec_t DEC_RST = '{size_sel: 3'b010, default: '0};

  logic [31:0]     r_q_instr [DEPTH];
  logic [PC_W-1:0] r_q_pc    [DEPTH];
  logic [AW-1:0]   r_wr, r_rd;
  logic [CW-1:0]   r_count;
  logic            r_full;
  logic [31:0]     r_instr;
  logic [PC_W-1:0] r_pc;
  dec_t            r_dec;
  state_t          r_state;

  logic [31:0] w_head;
  logic [6:0]  w_op, w_f7;
  logic [2:0]  w_f3;
  dec_t        w_dec;
  logic        w_ill;
  logic        w_valid, w_hs, w_push, w_load;

  assign w_head = r_q_instr[r_rd];
  assign w_op   = w_head[6:0];
  assign w_f3   = w_head[14:12];
  assign w_f7   = w_head[31:25];

  always_comb begin
    w_dec = DEC_RST;
    w_ill = 1'b0;
    case (w_op)
      7'b0110011: begin
        w_dec.regwrite = 1'b1;
        w_dec.aluctrl  = {w_f3, w_f7[5]};
        if (w_f7 == 7'b0000001) begin
          if (EN_M != 0) begin
            w_dec.compsel      = 1'b1;
            w_dec.mcycle_start = 1'b1;
            w_dec.mcycle_op    = {w_f3[2], (w_f3[2] ? w_f3[0] : w_f3[1])};
            w_dec.mcycle_sel   = !(w_f3 == 3'b000 || w_f3 == 3'b100 || w_f3 == 3'b101);
          end else begin
            w_ill = 1'b1;
          end
        end else if (w_f7 == 7'b0100000) begin
          w_ill = !(w_f3 == 3'b000 || w_f3 == 3'b101);
        end else if (w_f7 != 7'b0000000) begin
          w_ill = 1'b1;
        end
      end
      7'b0010011: begin
        w_dec.regwrite = 1'b1;
        w_dec.alusrcb  = 2'b11;
        w_dec.immsrc   = 3'b011;
        if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
          w_dec.aluctrl = {w_f3, w_f7[5]};
          w_ill = !(w_f7 == 7'b0000000 || (w_f3 == 3'b101 && w_f7 == 7'b0100000));
        end else begin
          w_dec.aluctrl = {w_f3, 1'b0};
        end
      end
      7'b0000011: begin
        w_dec.regwrite = 1'b1;
        w_dec.memtoreg = 1'b1;
        w_dec.alusrcb  = 2'b11;
        w_dec.immsrc   = 3'b011;
        w_dec.size_sel = w_f3;
        w_ill = (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111);
      end
      7'b0100011: begin
        w_dec.memwrite = 1'b1;
        w_dec.alusrcb  = 2'b11;
        w_dec.immsrc   = 3'b110;
        w_dec.size_sel = w_f3;
        w_ill = w_f3[2];
      end
      7'b1100011: begin
        w_dec.pcs     = 2'b01;
        w_dec.immsrc  = 3'b111;
        w_dec.aluctrl = 4'b0001;
        w_ill = (w_f3 == 3'b010 || w_f3 == 3'b011);
      end
      7'b1101111: begin
        w_dec.pcs      = 2'b10;
        w_dec.regwrite = 1'b1;
        w_dec.alusrca  = 2'b11;
        w_dec.alusrcb  = 2'b01;
        w_dec.immsrc   = 3'b010;
      end
      7'b1100111: begin
        w_dec.pcs      = 2'b11;
        w_dec.regwrite = 1'b1;
        w_dec.alusrca  = 2'b11;
        w_dec.alusrcb  = 2'b01;
        w_dec.immsrc   = 3'b011;
        w_ill = (w_f3 != 3'b000);
      end
      7'b0110111: begin
        w_dec.regwrite = 1'b1;
        w_dec.alusrca  = 2'b01;
        w_dec.alusrcb  = 2'b11;
      end
      7'b0010111: begin
        w_dec.regwrite = 1'b1;
        w_dec.alusrca  = 2'b11;
        w_dec.alusrcb  = 2'b11;
      end
      default: w_ill = 1'b1;
    endcase
    // Illegal entries still flow to issue, but with every side effect suppressed.
    w_dec.illegal = w_ill;
    if (w_ill) begin
      w_dec.regwrite     = 1'b0;
      w_dec.memwrite     = 1'b0;
      w_dec.memtoreg     = 1'b0;
      w_dec.mcycle_start = 1'b0;
      w_dec.compsel      = 1'b0;
      w_dec.pcs          = 2'b00;
    end
  end

  assign in_ready  = (r_count < CW'(DEPTH)) & ~flush;
  assign w_valid   = r_full & (r_state == RUN);
  assign w_hs      = w_valid & out_ready;
  assign w_push    = in_valid & in_ready;
  assign w_load    = (r_count != '0) & (~r_full | w_hs);

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_q_instr[r_wr] <= in_instr;
      r_q_pc[r_wr]    <= in_pc;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
      r_dec   <= DEC_RST;
      r_state <= RUN;
    end else if (flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
      r_dec   <= DEC_RST;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_load) r_rd <= r_rd + 1'b1;
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_load) begin
        r_full  <= 1'b1;
        r_instr <= w_head;
        r_pc    <= r_q_pc[r_rd];
        r_dec   <= w_dec;
      end else if (w_hs) begin
        r_full              <= 1'b0;
        r_dec.mcycle_start  <= 1'b0;
      end
      case (r_state)
        RUN:     if (w_hs && r_dec.mcycle_start) r_state <= MC_ARM;
        MC_ARM:  r_state <= mcycle_busy ? MC_WAIT : RUN;
        MC_WAIT: if (!mcycle_busy) r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

  assign out_valid        = w_valid;
  assign out_instr        = r_instr;
  assign out_pc           = r_pc;
  assign out_pcs          = r_dec.pcs;
  assign out_regwrite     = r_dec.regwrite;
  assign out_memwrite     = r_dec.memwrite;
  assign out_memtoreg     = r_dec.memtoreg;
  assign out_alusrca      = r_dec.alusrca;
  assign out_alusrcb      = r_dec.alusrcb;
  assign out_immsrc       = r_dec.immsrc;
  assign out_aluctrl      = r_dec.aluctrl;
  assign out_compsel      = r_dec.compsel;
  assign out_mcycle_start = r_dec.mcycle_start;
  assign out_mcycle_op    = r_dec.mcycle_op;
  assign out_mcycle_sel   = r_dec.mcycle_sel;
  assign out_size_sel     = r_dec.size_sel;
  assign out_illegal      = r_dec.illegal;
  assign count            = r_count;
endmodule

// File: tb/tb_decode_issue_unit.sv
// Randomized and directed bench for decode_issue_unit against a transaction-level
// queue model and an independent decode table.
module tb_decode_issue_unit;
  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_MUL = 32'h022081B3;
  localparam logic [31:0] I_DIV = 32'h0220C1B3;
  localparam logic [31:0] I_BAD = 32'h0000007F;

  logic CLK = 1'b0;
  logic RESET, in_valid, out_ready, flush, mcycle_busy;
  logic [31:0] in_instr;
  logic [PC_W-1:0] in_pc;

  logic in_ready, out_valid, out_regwrite, out_memwrite, out_memtoreg, out_compsel;
  logic out_mcycle_start, out_mcycle_sel, out_illegal;
  logic [31:0] out_instr;
  logic [PC_W-1:0] out_pc;
  logic [1:0] out_pcs, out_alusrca, out_alusrcb, out_mcycle_op;
  logic [2:0] out_immsrc, out_size_sel, count;
  logic [3:0] out_aluctrl;

  logic nm_in_ready, nm_out_valid, nm_regwrite, nm_memwrite, nm_memtoreg, nm_compsel;
  logic nm_mcycle_start, nm_mcycle_sel, nm_illegal;
  logic [31:0] nm_out_instr;
  logic [PC_W-1:0] nm_out_pc;
  logic [1:0] nm_pcs, nm_alusrca, nm_alusrcb, nm_mcycle_op;
  logic [2:0] nm_immsrc, nm_size_sel, nm_count;
  logic [3:0] nm_aluctrl;

  logic [24:0] dut_vec, nm_vec;

  always #5 CLK = ~CLK;

  decode_issue_unit #(.DEPTH(DEPTH), .PC_W(PC_W), .EN_M(1)) dut (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_pcs(out_pcs), .out_regwrite(out_regwrite),
    .out_memwrite(out_memwrite), .out_memtoreg(out_memtoreg), .out_alusrca(out_alusrca),
    .out_alusrcb(out_alusrcb), .out_immsrc(out_immsrc), .out_aluctrl(out_aluctrl),
    .out_compsel(out_compsel), .out_mcycle_start(out_mcycle_start),
    .out_mcycle_op(out_mcycle_op), .out_mcycle_sel(out_mcycle_sel),
    .out_size_sel(out_size_sel), .out_illegal(out_illegal), .flush(flush),
    .mcycle_busy(mcycle_busy), .count(count));

  decode_issue_unit #(.DEPTH(DEPTH), .PC_W(PC_W), .EN_M(0)) dut_nm (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(nm_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(nm_out_valid), .out_ready(out_ready),
    .out_instr(nm_out_instr), .out_pc(nm_out_pc), .out_pcs(nm_pcs), .out_regwrite(nm_regwrite),
    .out_memwrite(nm_memwrite), .out_memtoreg(nm_memtoreg), .out_alusrca(nm_alusrca),
    .out_alusrcb(nm_alusrcb), .out_immsrc(nm_immsrc), .out_aluctrl(nm_aluctrl),
    .out_compsel(nm_compsel), .out_mcycle_start(nm_mcycle_start),
    .out_mcycle_op(nm_mcycle_op), .out_mcycle_sel(nm_mcycle_sel),
    .out_size_sel(nm_size_sel), .out_illegal(nm_illegal), .flush(flush),
    .mcycle_busy(mcycle_busy), .count(nm_count));

  assign dut_vec = {out_pcs, out_regwrite, out_memwrite, out_memtoreg, out_alusrca, out_alusrcb,
                    out_immsrc, out_aluctrl, out_compsel, out_mcycle_start, out_mcycle_op,
                    out_mcycle_sel, out_size_sel, out_illegal};
  assign nm_vec  = {nm_pcs, nm_regwrite, nm_memwrite, nm_memtoreg, nm_alusrca, nm_alusrcb,
                    nm_immsrc, nm_aluctrl, nm_compsel, nm_mcycle_start, nm_mcycle_op,
                    nm_mcycle_sel, nm_size_sel, nm_illegal};

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference decode table; packing matches dut_vec. Bit 7 is mcycle_start.
  function automatic logic [24:0] ref_dec(input logic [31:0] ins, input bit en_m);
    logic [6:0] op, f7;
    logic [2:0] f3, imm, sz;
    logic [1:0] pcs, asa, asb, mop;
    logic [3:0] alu;
    bit rw, mw, mr, cs, ms, msel, ill;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    pcs = 0; asa = 0; asb = 0; mop = 0; alu = 0; imm = 0; sz = 3'b010;
    rw = 0; mw = 0; mr = 0; cs = 0; ms = 0; msel = 0; ill = 0;
    case (op)
      7'h33: begin
        rw = 1; alu = {f3, f7[5]};
        if (f7 == 7'h01) begin
          if (en_m) begin
            cs = 1; ms = 1;
            mop = f3[2] ? {1'b1, f3[0]} : {1'b0, f3[1]};
            msel = !(f3 inside {3'd0, 3'd4, 3'd5});
          end else ill = 1;
        end else if (!(f7 == 7'h00 || (f7 == 7'h20 && f3 inside {3'd0, 3'd5}))) ill = 1;
      end
      7'h13: begin
        rw = 1; asb = 3; imm = 3;
        if (f3 == 3'd1)      begin alu = {f3, f7[5]}; ill = (f7 != 0); end
        else if (f3 == 3'd5) begin alu = {f3, f7[5]}; ill = !(f7 inside {7'h00, 7'h20}); end
        else alu = {f3, 1'b0};
      end
      7'h03: begin rw = 1; mr = 1; asb = 3; imm = 3; sz = f3; ill = f3 inside {3'd3, 3'd6, 3'd7}; end
      7'h23: begin mw = 1; asb = 3; imm = 6; sz = f3; ill = (f3 > 3); end
      7'h63: begin pcs = 1; imm = 7; alu = 1; ill = f3 inside {3'd2, 3'd3}; end
      7'h6F: begin pcs = 2; rw = 1; asa = 3; asb = 1; imm = 2; end
      7'h67: begin pcs = 3; rw = 1; asa = 3; asb = 1; imm = 3; ill = (f3 != 0); end
      7'h37: begin rw = 1; asa = 1; asb = 3; end
      7'h17: begin rw = 1; asa = 3; asb = 3; end
      default: ill = 1;
    endcase
    if (ill) begin rw = 0; mw = 0; mr = 0; ms = 0; cs = 0; pcs = 0; end
    return {pcs, rw, mw, mr, asa, asb, imm, alu, cs, ms, mop, msel, sz, ill};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F, 7'h0B};
    logic [31:0] r;
    logic [6:0] f7;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h01;
      2: f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    return {f7, r[24:7], ops[$urandom_range(0, 10)]};
  endfunction

  typedef struct { logic [31:0] i; logic [PC_W-1:0] pc; } ent_t;
  ent_t m_q[$];
  ent_t m_cur;
  bit   m_full;
  int   m_phase;      // 0 issuing, 1 one-cycle arm, 2 waiting on busy
  logic [PC_W-1:0] m_pc_next = 32'h1000;

  task automatic model_clear();
    m_q.delete(); m_full = 0; m_phase = 0;
    m_cur.i = '0; m_cur.pc = '0;
  endtask

  task automatic do_reset(input bit busy);
    RESET = 1; in_valid = 0; in_instr = '0; in_pc = '0;
    out_ready = 0; flush = 0; mcycle_busy = busy;
    #1;
    check("rst_async_count", 64'(count), 64'd0);
    check("rst_async_valid", 64'(out_valid), 64'd0);
    @(posedge CLK); @(negedge CLK);
    RESET = 0;
    model_clear();
    check("rst_dec", 64'(dut_vec), 64'({21'd0, 3'b010, 1'b0}));
    check("rst_instr", 64'(out_instr), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  // One cycle: check current state at negedge, drive, advance model, cross posedge.
  task automatic step(input bit iv, input logic [31:0] ins, input bit ordy, input bit fl, input bit busy);
    bit exp_valid, hs;
    logic [24:0] cur_dec;
    exp_valid = m_full && (m_phase == 0);
    check("count", 64'(count), 64'(m_q.size()));
    check("out_valid", 64'(out_valid), 64'(exp_valid));
    if (exp_valid) begin
      check("out_instr", 64'(out_instr), 64'(m_cur.i));
      check("out_pc", 64'(out_pc), 64'(m_cur.pc));
      check("decode", 64'(dut_vec), 64'(ref_dec(m_cur.i, 1'b1)));
    end
    in_valid = iv; in_instr = ins; in_pc = m_pc_next;
    out_ready = ordy; flush = fl; mcycle_busy = busy;
    #1;
    check("in_ready", 64'(in_ready), 64'((m_q.size() < DEPTH) && !fl));
    hs = exp_valid && ordy;
    cur_dec = ref_dec(m_cur.i, 1'b1);
    if (fl) begin
      m_q.delete(); m_full = 0;
    end else begin
      bit acc;
      acc = iv && (m_q.size() < DEPTH);
      case (m_phase)
        0: if (hs && cur_dec[7]) m_phase = 1;
        1: m_phase = busy ? 2 : 0;
        default: if (!busy) m_phase = 0;
      endcase
      if (m_q.size() > 0 && (!m_full || hs)) begin
        m_cur = m_q.pop_front(); m_full = 1;
      end else if (hs) m_full = 0;
      if (acc) begin
        ent_t e;
        e.i = ins; e.pc = m_pc_next;
        m_q.push_back(e);
      end
    end
    m_pc_next = m_pc_next + 4;
    @(posedge CLK); @(negedge CLK);
  endtask

  initial begin
    do_reset(0);

    // ADD through an empty unit
    step(1, I_ADD, 1, 0, 0);
    step(0, '0, 1, 0, 0);
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_aluctrl", 64'(out_aluctrl), 64'd0);
    check("add_regwrite", 64'(out_regwrite), 64'd1);
    check("add_alusrcb", 64'(out_alusrcb), 64'd0);
    step(0, '0, 1, 0, 0);

    // Fill with output stalled, then pop alone, then pop with concurrent push
    for (int k = 0; k < 5; k++) step(1, I_ADD + 32'(k << 7), 0, 0, 0);
    check("full_count", 64'(count), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    step(1, I_ADD, 1, 0, 0);
    step(1, I_ADD, 1, 0, 0);
    check("pushpop_count", 64'(count), 64'd3);
    for (int k = 0; k < 8; k++) step(0, '0, 1, 0, 0);

    // MUL followed by ADD with the multi-cycle unit busy for 5 cycles
    step(1, I_MUL, 1, 0, 0);
    step(1, I_ADD, 1, 0, 0);
    check("mul_mstart", 64'(out_mcycle_start), 64'd1);
    check("mul_mop", 64'(out_mcycle_op), 64'd0);
    check("mul_msel", 64'(out_mcycle_sel), 64'd0);
    step(0, '0, 1, 0, 0);
    for (int k = 0; k < 5; k++) step(0, '0, 1, 0, 1);
    for (int k = 0; k < 4; k++) step(0, '0, 1, 0, 0);

    // Unknown opcode, and DIV with M decode disabled on the second instance
    do_reset(0);
    step(1, I_BAD, 1, 0, 0);
    step(1, I_DIV, 1, 0, 0);
    check("bad_illegal", 64'(out_illegal), 64'd1);
    check("bad_regwrite", 64'(out_regwrite), 64'd0);
    step(0, '0, 1, 0, 0);
    check("nm_valid", 64'(nm_out_valid), 64'd1);
    check("nm_instr", 64'(nm_out_instr), 64'(I_DIV));
    check("nm_illegal", 64'(nm_illegal), 64'd1);
    check("nm_regwrite", 64'(nm_regwrite), 64'd0);
    check("nm_mstart", 64'(nm_mcycle_start), 64'd0);
    check("nm_pcs", 64'(nm_pcs), 64'd0);
    check("nm_dec", 64'(nm_vec), 64'(ref_dec(I_DIV, 1'b0)));
    for (int k = 0; k < 4; k++) step(0, '0, 1, 0, 0);

    // Flush with three queued entries and a concurrent push
    for (int k = 0; k < 4; k++) step(1, I_ADD, 0, 0, 0);
    check("pre_flush_count", 64'(count), 64'd3);
    step(1, I_MUL, 0, 1, 0);
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    step(0, '0, 1, 0, 0);
    step(0, '0, 1, 0, 0);

    // Reset while waiting on the multi-cycle unit
    step(1, I_MUL, 1, 0, 1);
    step(1, I_ADD, 1, 0, 1);
    step(0, '0, 1, 0, 1);
    step(0, '0, 1, 0, 1);
    step(0, '0, 1, 0, 1);
    do_reset(1);
    step(1, I_ADD, 1, 0, 1);
    step(0, '0, 1, 0, 1);
    check("post_rst_valid", 64'(out_valid), 64'd1);
    step(0, '0, 1, 0, 0);

    // Random traffic
    for (int k = 0; k < 1500; k++)
      step($urandom_range(0, 9) < 7, rand_instr(), $urandom_range(0, 9) < 7,
           $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0);
    for (int k = 0; k < 20; k++) step(0, '0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
